unidade_controle: RTL and testbench



---
 rtl/proc_pkg.sv | 28 ++
 rtl/dec3to8.sv | 13 +
 rtl/unidade_controle.sv | 124 ++++++++++++
 tb/tb_unidade_controle.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/proc_pkg.sv
// Shared definitions for the 16-bit bus processor: opcodes, control states, IR fields.
package proc_pkg;

   typedef enum logic [1:0] {T0, T1, T2, T3} state_t;

   localparam logic [3:0] OP_MV   = 4'b0000;
   localparam logic [3:0] OP_MVI  = 4'b0001;
   localparam logic [3:0] OP_MVNZ = 4'b0010;
   localparam logic [3:0] OP_ADD  = 4'b0101;
   localparam logic [3:0] OP_SUB  = 4'b0110;
   localparam logic [3:0] OP_OR   = 4'b0111;
   localparam logic [3:0] OP_SLT  = 4'b1000;
   localparam logic [3:0] OP_SLL  = 4'b1001;
   localparam logic [3:0] OP_SRL  = 4'b1010;

   localparam int OPC_HI = 15;
   localparam int OPC_LO = 12;
   localparam int RX_HI  = 11;
   localparam int RX_LO  = 9;
   localparam int RY_HI  = 8;
   localparam int RY_LO  = 6;

   function automatic logic is_alu_op(input logic [3:0] op);
      return (op == OP_ADD) || (op == OP_SUB) || (op == OP_OR) ||
             (op == OP_SLT) || (op == OP_SLL) || (op == OP_SRL);
   endfunction

endpackage

// File: rtl/dec3to8.sv
// 3-to-8 one-hot decoder with enable.
module dec3to8 (
   input  logic [2:0] i_sel,
   input  logic       i_en,
   output logic [7:0] o_onehot
);

   always_comb begin
      o_onehot = '0;
      if (i_en) o_onehot = 8'b1 << i_sel;
   end

endmodule

// File: rtl/unidade_controle.sv
// Multicycle control unit: latches the instruction in T0 and sequences T1..T3,
// decoding all datapath enables from the current state and IR.
module unidade_controle
   import proc_pkg::*;
#(
   parameter int NREG = 8
) (
   input  logic            Clock,
   input  logic            Reset,
   input  logic            Run,
   input  logic [15:0]     DIN,
   input  logic            GNZ,
   output logic [NREG-1:0] Rin,
   output logic [NREG-1:0] Rout,
   output logic            Ain,
   output logic            Gin,
   output logic            Gout,
   output logic            DINout,
   output logic [3:0]      ULAop,
   output logic            Busy,
   output logic            Done
);

   state_t      r_state;
   logic [15:6] r_ir;

   logic [3:0]      w_op;
   logic            w_alu;
   logic            w_busy;
   logic [NREG-1:0] w_rx_1h;
   logic [NREG-1:0] w_ry_1h;
   logic            w_rin_x;
   logic            w_rout_x;
   logic            w_rout_y;
   logic            w_unused;

   // Low six instruction bits carry no meaning and are never stored.
   assign w_unused = ^DIN[5:0];
   assign w_op     = r_ir[OPC_HI:OPC_LO];
   assign w_alu    = is_alu_op(w_op);
   assign w_busy   = (r_state != T0);

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         r_state <= T0;
         r_ir    <= '0;
      end else begin
         unique case (r_state)
            T0: if (Run) begin
                   r_ir    <= DIN[15:6];
                   r_state <= T1;
                end
            T1: r_state <= w_alu ? T2 : T0;
            T2: r_state <= T3;
            T3: r_state <= T0;
         endcase
      end
   end

   dec3to8 u_dec_rx (
      .i_sel    (r_ir[RX_HI:RX_LO]),
      .i_en     (w_busy),
      .o_onehot (w_rx_1h)
   );

   dec3to8 u_dec_ry (
      .i_sel    (r_ir[RY_HI:RY_LO]),
      .i_en     (w_busy),
      .o_onehot (w_ry_1h)
   );

   always_comb begin
      w_rin_x  = 1'b0;
      w_rout_x = 1'b0;
      w_rout_y = 1'b0;
      Ain      = 1'b0;
      Gin      = 1'b0;
      Gout     = 1'b0;
      DINout   = 1'b0;
      ULAop    = '0;
      Done     = 1'b0;
      unique case (r_state)
         T0: ;
         T1: begin
            if (w_alu) begin
               w_rout_x = 1'b1;
               Ain      = 1'b1;
            end else begin
               Done = 1'b1;
               case (w_op)
                  OP_MV: begin
                     w_rout_y = 1'b1;
                     w_rin_x  = 1'b1;
                  end
                  OP_MVI: begin
                     DINout  = 1'b1;
                     w_rin_x = 1'b1;
                  end
                  OP_MVNZ: begin
                     w_rout_y = GNZ;
                     w_rin_x  = GNZ;
                  end
                  default: ;
               endcase
            end
         end
         T2: begin
            w_rout_y = 1'b1;
            Gin      = 1'b1;
            ULAop    = w_op;
         end
         T3: begin
            Gout    = 1'b1;
            w_rin_x = 1'b1;
            Done    = 1'b1;
         end
      endcase
      Busy = w_busy;
      Rin  = w_rin_x ? w_rx_1h : '0;
      // Rx and Ry reads never coincide, so Rout stays one-hot even when Rx == Ry.
      Rout = w_rout_x ? w_rx_1h : (w_rout_y ? w_ry_1h : '0);
   end

endmodule

// File: tb/tb_unidade_controle.sv
// Self-checking bench for unidade_controle: directed cases plus a random instruction stream.
module tb_unidade_controle;

   logic        Clock = 1'b0;
   logic        Reset;
   logic        Run;
   logic [15:0] DIN;
   logic        GNZ;
   logic [7:0]  Rin;
   logic [7:0]  Rout;
   logic        Ain, Gin, Gout, DINout, Busy, Done;
   logic [3:0]  ULAop;
   logic [25:0] obs;

   int tests = 0;
   int fails = 0;
   int accepted = 0;
   int dones = 0;
   int m_step = 0;
   logic [15:0] m_ir = '0;

   always #5 Clock = ~Clock;

   unidade_controle #(.NREG(8)) dut (
      .Clock  (Clock),
      .Reset  (Reset),
      .Run    (Run),
      .DIN    (DIN),
      .GNZ    (GNZ),
      .Rin    (Rin),
      .Rout   (Rout),
      .Ain    (Ain),
      .Gin    (Gin),
      .Gout   (Gout),
      .DINout (DINout),
      .ULAop  (ULAop),
      .Busy   (Busy),
      .Done   (Done)
   );

   assign obs = {Rin, Rout, Ain, Gin, Gout, DINout, ULAop, Busy, Done};

   // Expected outputs for a given step (0 = idle, 1..3 = cycles after acceptance).
   function automatic logic [25:0] exp_out(input int step, input logic [15:0] ir, input logic gnz);
      logic [3:0] op;
      logic [7:0] x, y, rin, rout;
      logic ain, gin, gout, dinout, done, alu;
      logic [3:0] ula;
      op  = ir[15:12];
      x   = 8'(1 << ir[11:9]);
      y   = 8'(1 << ir[8:6]);
      alu = (op >= 4'd5) && (op <= 4'd10);
      rin = '0; rout = '0; ain = 0; gin = 0; gout = 0; dinout = 0; done = 0; ula = '0;
      if (step == 1) begin
         if (alu) begin rout = x; ain = 1; end
         else begin
            done = 1;
            if (op == 4'd0) begin rout = y; rin = x; end
            if (op == 4'd1) begin dinout = 1; rin = x; end
            if (op == 4'd2 && gnz) begin rout = y; rin = x; end
         end
      end else if (step == 2) begin
         rout = y; gin = 1; ula = op;
      end else if (step == 3) begin
         gout = 1; rin = x; done = 1;
      end
      return {rin, rout, ain, gin, gout, dinout, ula, 1'(step != 0), done};
   endfunction

   task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
      tests++;
      assert (o === e) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
      end
   endtask

   // Apply inputs for the current cycle and check outputs against the model.
   task automatic drive(input logic run, input logic [15:0] din, input logic gnz);
      Run = run; DIN = din; GNZ = gnz;
      #1;
      chk("outputs", 32'(obs), 32'(exp_out(m_step, m_ir, gnz)));
      chk("bus_drivers", 32'($countones({Rout, Gout, DINout}) <= 1), 32'd1);
      chk("ulaop_t2_only", 32'((ULAop != 4'd0) && (m_step != 2)), 32'd0);
      if (Done) dones++;
   endtask

   task automatic tick();
      logic [3:0] op;
      @(posedge Clock);
      op = m_ir[15:12];
      case (m_step)
         0: if (Run) begin m_ir = DIN; m_step = 1; accepted++; end
         1: m_step = (op >= 4'd5 && op <= 4'd10) ? 2 : 0;
         2: m_step = 3;
         default: m_step = 0;
      endcase
      #1;
   endtask

   initial begin
      int cyc;
      Reset = 1'b1; Run = 1'b0; DIN = '0; GNZ = 1'b0;
      #2;
      chk("reset_state", 32'(obs), 32'd0);
      @(posedge Clock); #1;
      Reset = 1'b0;

      // add R1,R5 aborted by reset in T2
      drive(1'b1, 16'h5340, 1'b0); tick();
      drive(1'b0, 16'h0000, 1'b0); tick();
      drive(1'b0, 16'h0000, 1'b0);
      chk("add_T2_ula", 32'(ULAop), 32'h5);
      #1 Reset = 1'b1;
      #1 chk("reset_midinstr", 32'(obs), 32'd0);
      m_step = 0; m_ir = '0;
      #1 Reset = 1'b0;
      tick();
      drive(1'b0, 16'h0000, 1'b0);
      chk("post_reset_busy", 32'(Busy), 32'd0);
      tick();
      accepted = 0; dones = 0;

      // mvi R2, #0x1234
      drive(1'b1, 16'h1400, 1'b0); tick();
      drive(1'b0, 16'h1234, 1'b0);
      chk("mvi_T1", 32'({DINout, Rin, Done}), 32'({1'b1, 8'h04, 1'b1}));
      tick();
      drive(1'b0, 16'h0000, 1'b0);
      chk("mvi_after_busy", 32'(Busy), 32'd0);
      tick();

      // add R1,R5
      drive(1'b1, 16'h5340, 1'b0); tick();
      drive(1'b0, 16'h0000, 1'b0);
      chk("add_T1", 32'({Rout, Ain}), 32'({8'h02, 1'b1})); tick();
      drive(1'b0, 16'h0000, 1'b0);
      chk("add_T2", 32'({Rout, Gin, ULAop}), 32'({8'h20, 1'b1, 4'h5})); tick();
      drive(1'b0, 16'h0000, 1'b0);
      chk("add_T3", 32'({Gout, Rin, Done}), 32'({1'b1, 8'h02, 1'b1})); tick();

      // mvnz R0,R7 with GNZ low then high
      drive(1'b1, 16'h21C0, 1'b0); tick();
      drive(1'b0, 16'h0000, 1'b0);
      chk("mvnz_gnz0", 32'({Rin, Rout, Done}), 32'({8'h00, 8'h00, 1'b1})); tick();
      drive(1'b1, 16'h21C0, 1'b0); tick();
      drive(1'b0, 16'h0000, 1'b1);
      chk("mvnz_gnz1", 32'({Rout, Rin, Done}), 32'({8'h80, 8'h01, 1'b1})); tick();

      // reserved opcode, then mv R4,R4 back-to-back
      drive(1'b1, 16'hB000, 1'b0); tick();
      drive(1'b1, 16'h0900, 1'b0);
      chk("reserved_T1", 32'({Rin, Rout, Ain, Gin, Gout, DINout, Done}), 32'({8'h00, 8'h00, 5'b00001}));
      tick();
      drive(1'b1, 16'h0900, 1'b0);
      chk("b2b_idle", 32'(Busy), 32'd0); tick();
      drive(1'b0, 16'h0000, 1'b0);
      chk("mv_r4r4", 32'({Rout, Rin, Done}), 32'({8'h10, 8'h10, 1'b1})); tick();

      // random instruction stream
      cyc = 0;
      while (accepted < 5000 + 7 && cyc < 60000) begin
         drive(1'($urandom_range(0, 1)), 16'($urandom), 1'($urandom_range(0, 1)));
         tick();
         cyc++;
      end
      chk("random_budget", 32'(accepted >= 5007), 32'd1);
      for (int i = 0; i < 4; i++) begin
         drive(1'b0, 16'h0000, 1'b0);
         tick();
      end
      chk("done_per_instr", 32'(dones), 32'(accepted));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
